// File: rtl/dualport_ram_be.sv
// Simple-dual-port RAM with byte-lane write enables, RLAT 1/2 read pipeline and a zero-clear
// sweep after reset. Define DPRAM_BE_PARITY_EN to store and check per-lane even parity.
module dualport_ram_be #(
    parameter int unsigned AWIDTH     = 9,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned BWIDTH     = 8,
    parameter int unsigned RLAT       = 1,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                     wclk,
    input  logic                     rclk,
    input  logic                     arst_n,
    input  logic                     wen,
    input  logic [DWIDTH/BWIDTH-1:0] wbe,
    input  logic [AWIDTH-1:0]        waddr,
    input  logic [DWIDTH-1:0]        wdata,
    output logic                     wready,
    input  logic                     ren,
    input  logic [AWIDTH-1:0]        raddr,
    output logic                     rdv,
    output logic [DWIDTH-1:0]        rdata,
    output logic                     rperr
);

    localparam int unsigned NB    = DWIDTH / BWIDTH;
    localparam int unsigned DEPTH = 1 << AWIDTH;

    typedef enum logic [0:0] {StClear, StReady} init_state_e;

    init_state_e       state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_we;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic              rdv_q;
    logic [DWIDTH-1:0] rdata_q;

    // ---------------------------------------------------------------- init FSM
    always_ff @(posedge wclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            StClear: begin
                if (INIT_CLEAR != 0) begin
                    clr_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_d = StReady;
                    end
                end else begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
        endcase
    end

    assign wready = (state_q == StReady);

    // ---------------------------------------------------------------- write port
    // The clear sweep owns the array until wready, so user writes are simply ignored then.
    always_ff @(posedge wclk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (wready && wen) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BWIDTH +: BWIDTH] <= wdata[i*BWIDTH +: BWIDTH];
                end
            end
        end
    end

`ifdef DPRAM_BE_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic          rperr_q;

    always_ff @(posedge wclk) begin
        if (clr_we) begin
            par_mem[clr_cnt_q] <= '0;
        end else if (wready && wen) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    par_mem[waddr][i] <= ^wdata[i*BWIDTH +: BWIDTH];
                end
            end
        end
    end

    function automatic logic par_err(input logic [DWIDTH-1:0] d, input logic [NB-1:0] p);
        logic e;
        e = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            e = e | (^d[i*BWIDTH +: BWIDTH] ^ p[i]);
        end
        return e;
    endfunction

    assign rperr = rperr_q;
`else
    assign rperr = 1'b0;
`endif

    // ---------------------------------------------------------------- read port
    if (RLAT == 2) begin : g_rlat2
        logic              s1_vld_q;
        logic [DWIDTH-1:0] s1_data_q;

        always_ff @(posedge rclk or negedge arst_n) begin
            if (!arst_n) begin
                s1_vld_q  <= 1'b0;
                s1_data_q <= '0;
                rdv_q     <= 1'b0;
                rdata_q   <= '0;
            end else begin
                s1_vld_q <= ren;
                if (ren) begin
                    s1_data_q <= mem[raddr];
                end
                rdv_q <= s1_vld_q;
                if (s1_vld_q) begin
                    rdata_q <= s1_data_q;
                end
            end
        end

`ifdef DPRAM_BE_PARITY_EN
        logic [NB-1:0] s1_par_q;

        // Parity is checked in the output stage so rperr lines up with rdv.
        always_ff @(posedge rclk or negedge arst_n) begin
            if (!arst_n) begin
                s1_par_q <= '0;
                rperr_q  <= 1'b0;
            end else begin
                if (ren) begin
                    s1_par_q <= par_mem[raddr];
                end
                rperr_q <= s1_vld_q && par_err(s1_data_q, s1_par_q);
            end
        end
`endif
    end else begin : g_rlat1
        always_ff @(posedge rclk or negedge arst_n) begin
            if (!arst_n) begin
                rdv_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                rdv_q <= ren;
                if (ren) begin
                    rdata_q <= mem[raddr];
                end
            end
        end

`ifdef DPRAM_BE_PARITY_EN
        always_ff @(posedge rclk or negedge arst_n) begin
            if (!arst_n) begin
                rperr_q <= 1'b0;
            end else begin
                rperr_q <= ren && par_err(mem[raddr], par_mem[raddr]);
            end
        end
`endif
    end

    assign rdv   = rdv_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dualport_ram_be.sv
// Scoreboard bench for dualport_ram_be (AWIDTH=4, RLAT=2, INIT_CLEAR=1) on unrelated clocks.
module tb_dualport_ram_be;

    logic        wclk   = 1'b0;
    logic        rclk   = 1'b0;
    logic        arst_n = 1'b0;
    logic        wen    = 1'b0;
    logic [1:0]  wbe    = '0;
    logic [3:0]  waddr  = '0;
    logic [15:0] wdata  = '0;
    logic        ren    = 1'b0;
    logic [3:0]  raddr  = '0;
    logic        wready;
    logic        rdv;
    logic [15:0] rdata;
    logic        rperr;

    dualport_ram_be #(
        .AWIDTH     (4),
        .DWIDTH     (16),
        .BWIDTH     (8),
        .RLAT       (2),
        .INIT_CLEAR (1)
    ) dut (
        .wclk   (wclk),
        .rclk   (rclk),
        .arst_n (arst_n),
        .wen    (wen),
        .wbe    (wbe),
        .waddr  (waddr),
        .wdata  (wdata),
        .wready (wready),
        .ren    (ren),
        .raddr  (raddr),
        .rdv    (rdv),
        .rdata  (rdata),
        .rperr  (rperr)
    );

    always #5 wclk = ~wclk;
    always #14 rclk = ~rclk;

    typedef struct packed {
        logic [15:0] d;
        logic        p;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] model [16];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rdv pulse consumes one expected entry.
    always @(posedge rclk) begin
        #1;
        if (rdv === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdv: got rdata %0h with no read outstanding", rdata);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", {16'h0, rdata}, {16'h0, mon_e.d});
                check("rperr", {31'h0, rperr}, {31'h0, mon_e.p});
            end
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge wclk);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        wbe   = be;
        @(negedge wclk);
        wen = 1'b0;
        wbe = '0;
        for (int i = 0; i < 2; i++) begin
            if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input logic p);
        @(negedge rclk);
        ren   = 1'b1;
        raddr = a;
        sb.push_back('{d: exp, p: p});
        @(negedge rclk);
        ren = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge rclk);
        #2;
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic wait_ready(input string name);
        int seen;
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge wclk);
            #1;
            if (wready === 1'b1) begin
                seen = n;
                break;
            end
        end
        check(name, seen, 16);
    endtask

    initial begin
        int seen;
        logic [3:0]  ra;
        logic [15:0] rd;
        logic [1:0]  rb;

        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset values.
        #23;
        check("rst_wready", {31'h0, wready}, 0);
        check("rst_rdv", {31'h0, rdv}, 0);
        check("rst_rdata", {16'h0, rdata}, 0);
        check("rst_rperr", {31'h0, rperr}, 0);

        // Init sweep with an early write on edge 3 that must be dropped.
        @(negedge wclk);
        arst_n = 1'b1;
        seen   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge wclk);
            #1;
            if (n == 2) begin
                wen   = 1'b1;
                waddr = 4'd7;
                wdata = 16'hBEEF;
                wbe   = 2'b11;
            end
            if (n == 3) begin
                wen = 1'b0;
                wbe = '0;
            end
            if (wready === 1'b1) begin
                seen = n;
                break;
            end
        end
        check("init_edges", seen, 16);
        for (int a = 0; a < 16; a++) do_read(4'(a), 16'h0000, 1'b0);
        drain();

        // Byte enables, including an all-lanes-off no-op.
        do_write(4'd5, 16'hAAAA, 2'b11);
        do_write(4'd5, 16'h1234, 2'b01);
        do_read(4'd5, 16'hAA34, 1'b0);
        do_write(4'd5, 16'hFFFF, 2'b00);
        do_read(4'd5, 16'hAA34, 1'b0);
        do_write(4'd6, 16'h5678, 2'b10);
        do_read(4'd6, 16'h5600, 1'b0);
        drain();

        // Back-to-back reads through the two-stage pipeline.
        do_write(4'd1, 16'hC001, 2'b11);
        do_write(4'd2, 16'hC002, 2'b11);
        do_write(4'd3, 16'hC003, 2'b11);
        @(negedge rclk);
        ren   = 1'b1;
        raddr = 4'd1;
        sb.push_back('{d: 16'hC001, p: 1'b0});
        @(posedge rclk); #2;
        check("lat_e1_rdv", {31'h0, rdv}, 0);
        @(negedge rclk);
        raddr = 4'd2;
        sb.push_back('{d: 16'hC002, p: 1'b0});
        @(posedge rclk); #2;
        check("lat_e2_rdv", {31'h0, rdv}, 1);
        @(negedge rclk);
        raddr = 4'd3;
        sb.push_back('{d: 16'hC003, p: 1'b0});
        @(posedge rclk); #2;
        check("lat_e3_rdv", {31'h0, rdv}, 1);
        @(negedge rclk);
        ren = 1'b0;
        @(posedge rclk); #2;
        check("lat_e4_rdv", {31'h0, rdv}, 1);
        @(posedge rclk); #2;
        check("lat_e5_rdv", {31'h0, rdv}, 0);
        check("lat_e5_hold", {16'h0, rdata}, 32'hC003);
        @(posedge rclk); #2;
        check("lat_e6_hold", {16'h0, rdata}, 32'hC003);
        drain();

        // Unrelated clocks: write then read the same address, model tracks lanes.
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            rb = 2'($urandom_range(0, 3));
            do_write(ra, rd, rb);
            do_read(ra, model[ra], 1'b0);
        end
        drain();

        // Async reset clears outputs immediately.
        do_write(4'd9, 16'h5A5A, 2'b11);
        do_read(4'd9, 16'h5A5A, 1'b0);
        drain();
        arst_n = 1'b0;
        #1;
        check("arst_wready", {31'h0, wready}, 0);
        check("arst_rdata", {16'h0, rdata}, 0);
        check("arst_rdv", {31'h0, rdv}, 0);
        check("arst_rperr", {31'h0, rperr}, 0);
        #20;
        @(negedge wclk);
        arst_n = 1'b1;
        repeat (7) @(posedge wclk);
        #1;
        check("clr7_wready", {31'h0, wready}, 0);
        arst_n = 1'b0;
        #1;
        check("midclr_wready", {31'h0, wready}, 0);
        check("midclr_rdv", {31'h0, rdv}, 0);
        check("midclr_rdata", {16'h0, rdata}, 0);
        check("midclr_rperr", {31'h0, rperr}, 0);
        #20;
        @(negedge wclk);
        arst_n = 1'b1;
        wait_ready("reclear_edges");
        for (int i = 0; i < 16; i++) model[i] = '0;
        do_read(4'd9, 16'h0000, 1'b0);
        do_read(4'd15, 16'h0000, 1'b0);
        do_read(4'd0, 16'h0000, 1'b0);
        drain();

`ifdef DPRAM_BE_PARITY_EN
        // Corrupt one stored bit behind the parity.
        do_write(4'd2, 16'h00FF, 2'b11);
        dut.mem[2][0] = ~dut.mem[2][0];
        do_read(4'd2, 16'h00FE, 1'b1);
        do_read(4'd9, 16'h0000, 1'b0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
